// File: rtl/sha1_pkg.sv
// Shared constants and types for the SHA-1 feeder: initial hash value, FSM states,
// and the big-endian byte-lane mapping used by the block buffer.
package sha1_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NWORDS = 16;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hc3d2e1f0;

    typedef enum logic [2:0] {
        FILL,
        PAD80,
        PADZ,
        LEN,
        RUN,
        WAIT,
        ACC,
        DONE
    } state_t;

    // Byte 0 of a word occupies the most significant lane.
    function automatic logic [1:0] byte_lane(input logic [1:0] k);
        return 2'(2'd3 - k);
    endfunction

endpackage

// File: rtl/sha1_blkbuf.sv
// 16x32 message block buffer: byte-lane writes from the stream, a 64-bit length write
// into words 14/15, and an asynchronous word read port for the compression core.
module sha1_blkbuf
    import sha1_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                clr,
    input  logic                byte_we,
    input  logic [5:0]          byte_addr,
    input  logic [7:0]          byte_data,
    input  logic                len_we,
    input  logic [63:0]         len_data,
    input  logic [3:0]          raddr,
    output logic [WORD_W-1:0]   rdata_c
);

    logic [WORD_W-1:0] mem [NWORDS];
    logic [4:0]        lane_lsb;

    assign lane_lsb = {byte_lane(byte_addr[1:0]), 3'b000};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (byte_we) begin
                mem[byte_addr[5:2]][lane_lsb +: 8] <= byte_data;
            end
            if (len_we) begin
                mem[14] <= len_data[63:32];
                mem[15] <= len_data[31:0];
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/sha1_feeder.sv
// SHA-1 front end: packs the byte stream into 512-bit blocks, applies padding and the
// bit-length trailer, sequences the compression core and accumulates the digest.
module sha1_feeder
    import sha1_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic         core_restart,
    output logic [31:0]  core_word,
    input  logic [3:0]   core_raddr,
    input  logic [31:0]  core_a,
    input  logic [31:0]  core_b,
    input  logic [31:0]  core_c,
    input  logic [31:0]  core_d,
    input  logic [31:0]  core_e,
    input  logic         core_ready,
    output logic [31:0]  h0,
    output logic [31:0]  h1,
    output logic [31:0]  h2,
    output logic [31:0]  h3,
    output logic [31:0]  h4,
    output logic [159:0] digest,
    output logic         digest_valid
);

    state_t             state;
    logic [6:0]         byte_idx;
    logic [LEN_W-1:0]   bitlen;
    logic               final_blk;
    logic               ovf;
    logic               pend_pad;
    logic               wait_arm;

    logic               accept;
    logic               buf_byte_we;
    logic [7:0]         buf_byte_data;
    logic               buf_len_we;
    logic               buf_clr;
    logic [31:0]        sum_a, sum_b, sum_c, sum_d, sum_e;

    assign accept = in_valid & in_ready & ((state == FILL) | (state == DONE));

    assign sum_a = h0 + core_a;
    assign sum_b = h1 + core_b;
    assign sum_c = h2 + core_c;
    assign sum_d = h3 + core_d;
    assign sum_e = h4 + core_e;

    // Buffer write strobes follow the current state; the buffer is untouched in RUN/WAIT.
    always_comb begin
        buf_byte_we   = 1'b0;
        buf_byte_data = in_data;
        buf_len_we    = 1'b0;
        buf_clr       = 1'b0;
        case (state)
            FILL, DONE: buf_byte_we = accept;
            PAD80: begin
                buf_byte_we   = 1'b1;
                buf_byte_data = 8'h80;
            end
            PADZ: begin
                buf_byte_we   = ovf ? (byte_idx != 7'd64) : (byte_idx != 7'd56);
                buf_byte_data = 8'h00;
            end
            LEN:     buf_len_we = 1'b1;
            ACC:     buf_clr    = 1'b1;
            default: buf_byte_we = 1'b0;
        endcase
    end

    sha1_blkbuf u_blkbuf (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (buf_clr),
        .byte_we   (buf_byte_we),
        .byte_addr (byte_idx[5:0]),
        .byte_data (buf_byte_data),
        .len_we    (buf_len_we),
        .len_data  (64'(bitlen)),
        .raddr     (core_raddr),
        .rdata_c   (core_word)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= FILL;
            byte_idx     <= '0;
            bitlen       <= '0;
            final_blk    <= 1'b0;
            ovf          <= 1'b0;
            pend_pad     <= 1'b0;
            wait_arm     <= 1'b0;
            in_ready     <= 1'b0;
            core_restart <= 1'b0;
            h0           <= IV0;
            h1           <= IV1;
            h2           <= IV2;
            h3           <= IV3;
            h4           <= IV4;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            core_restart <= 1'b0;
            case (state)
                FILL, DONE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        byte_idx <= byte_idx + 7'd1;
                        // First byte after a finished digest starts a fresh message.
                        if (state == DONE) begin
                            h0           <= IV0;
                            h1           <= IV1;
                            h2           <= IV2;
                            h3           <= IV3;
                            h4           <= IV4;
                            bitlen       <= LEN_W'(8);
                            digest_valid <= 1'b0;
                        end else begin
                            bitlen <= bitlen + LEN_W'(8);
                        end
                        if (byte_idx == 7'd63) begin
                            in_ready     <= 1'b0;
                            pend_pad     <= in_last;
                            core_restart <= 1'b1;
                            state        <= RUN;
                        end else if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= PAD80;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                PAD80: begin
                    byte_idx <= byte_idx + 7'd1;
                    ovf      <= (byte_idx >= 7'd56);
                    state    <= PADZ;
                end
                PADZ: begin
                    if (ovf && (byte_idx == 7'd64)) begin
                        core_restart <= 1'b1;
                        state        <= RUN;
                    end else if (!ovf && (byte_idx == 7'd56)) begin
                        state <= LEN;
                    end else begin
                        byte_idx <= byte_idx + 7'd1;
                    end
                end
                LEN: begin
                    final_blk    <= 1'b1;
                    core_restart <= 1'b1;
                    state        <= RUN;
                end
                RUN: begin
                    wait_arm <= 1'b0;
                    state    <= WAIT;
                end
                // core_ready is not trusted until one full cycle after the restart pulse.
                WAIT: begin
                    if (!wait_arm) begin
                        wait_arm <= 1'b1;
                    end else if (core_ready) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    h0       <= sum_a;
                    h1       <= sum_b;
                    h2       <= sum_c;
                    h3       <= sum_d;
                    h4       <= sum_e;
                    byte_idx <= '0;
                    if (final_blk) begin
                        final_blk    <= 1'b0;
                        digest       <= {sum_a, sum_b, sum_c, sum_d, sum_e};
                        digest_valid <= 1'b1;
                        in_ready     <= 1'b1;
                        state        <= DONE;
                    end else if (pend_pad) begin
                        pend_pad <= 1'b0;
                        state    <= PAD80;
                    end else if (ovf) begin
                        ovf   <= 1'b0;
                        state <= PADZ;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_feeder.sv
// Bench for sha1_feeder: a behavioural SHA-1 core answers restarts, and a byte-queue
// SHA-1 reference predicts every digest and the number of blocks per message.
module tb_sha1_feeder;

    localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_FOX = 160'h2fd4e1c6_7a2d28fc_ed849ee1_bb76e739_1b93eb12;
    localparam logic [159:0] DIG_56  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    typedef logic [7:0] msg_t [$];

    logic         clk = 1'b0;
    logic         nrst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         core_restart;
    logic [31:0]  core_word;
    logic [3:0]   core_raddr = '0;
    logic [31:0]  core_a = '0, core_b = '0, core_c = '0, core_d = '0, core_e = '0;
    logic         core_ready = 1'b0;
    logic [31:0]  h0, h1, h2, h3, h4;
    logic [159:0] digest;
    logic         digest_valid;

    int checks = 0;
    int errors = 0;

    logic [159:0] exp_dig_q [$];
    int           exp_blk_q [$];

    always #5 clk = ~clk;

    sha1_feeder #(.LEN_W(64)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .core_restart (core_restart),
        .core_word    (core_word),
        .core_raddr   (core_raddr),
        .core_a       (core_a),
        .core_b       (core_b),
        .core_c       (core_c),
        .core_d       (core_d),
        .core_e       (core_e),
        .core_ready   (core_ready),
        .h0           (h0),
        .h1           (h1),
        .h2           (h2),
        .h3           (h3),
        .h4           (h4),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // One SHA-1 compression: returns the working variables before the feed-forward add.
    function automatic logic [159:0] compress(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        {a, b, c, d, e} = hin;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            t = rol(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rol(b, 30); b = a; a = t;
        end
        return {a, b, c, d, e};
    endfunction

    function automatic logic [159:0] add5(input logic [159:0] x, input logic [159:0] y);
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    function automatic logic [159:0] sha1_ref(input msg_t m);
        msg_t         p;
        logic [63:0]  bl;
        logic [159:0] h;
        logic [511:0] blk;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        h = IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*bi + j];
            h = add5(h, compress(h, blk));
        end
        return h;
    endfunction

    function automatic msg_t str2msg(input string s);
        msg_t m;
        for (int i = 0; i < s.len(); i++) m.push_back(8'(s[i]));
        return m;
    endfunction

    // Behavioural compression core: reads 16 words, may assert a stale core_ready inside
    // the ignore window, then returns the real working variables after a random delay.
    logic [511:0] cm_blk;
    logic [159:0] cm_h;
    int           cm_phase = 0;
    int           cm_delay = 0;

    always @(negedge clk) begin
        if (!nrst) begin
            cm_phase   = 0;
            core_ready = 1'b0;
        end else if (cm_phase == 0) begin
            core_ready = 1'b0;
            if (core_restart) begin
                cm_h = {h0, h1, h2, h3, h4};
                if ($urandom_range(0, 1) == 1) begin
                    core_ready = 1'b1;
                    {core_a, core_b, core_c, core_d, core_e} = {$urandom, $urandom, $urandom, $urandom, $urandom};
                end
                core_raddr = 4'd0;
                #1;
                cm_blk[511 -: 32] = core_word;
                cm_phase = 2;
            end
        end else if (cm_phase <= 16) begin
            if (cm_phase >= 3) core_ready = 1'b0;
            core_raddr = 4'(cm_phase - 1);
            #1;
            cm_blk[511 - 32*(cm_phase - 1) -: 32] = core_word;
            cm_phase++;
            if (cm_phase == 17) cm_delay = $urandom_range(0, 4);
        end else begin
            core_ready = 1'b0;
            if (cm_delay == 0) begin
                check("h_stable", {h0, h1, h2, h3, h4}, cm_h);
                {core_a, core_b, core_c, core_d, core_e} = compress(cm_h, cm_blk);
                core_ready = 1'b1;
                cm_phase   = 0;
            end else begin
                cm_delay--;
            end
        end
    end

    // Compare process: digests against the scoreboard, block counts, in_ready while busy,
    // and the digest_valid drop / IV reload on a new message's first byte.
    bit dv_prev  = 1'b0;
    bit acc_prev = 1'b0;
    bit busy     = 1'b0;
    int rst_cnt  = 0;

    always @(negedge clk) begin
        if (!nrst) begin
            dv_prev  = 1'b0;
            acc_prev = 1'b0;
            busy     = 1'b0;
            rst_cnt  = 0;
            exp_dig_q.delete();
            exp_blk_q.delete();
        end else begin
            if (core_restart) rst_cnt++;
            if (dv_prev && acc_prev) begin
                check("dv_drop", 160'(digest_valid), 160'(0));
                check("h_iv_reload", {h0, h1, h2, h3, h4}, IV);
            end
            if (digest_valid && !dv_prev) begin
                busy = 1'b0;
                if (exp_dig_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_digest: got %h expected none", digest);
                end else begin
                    logic [159:0] ed;
                    int           eb;
                    ed = exp_dig_q.pop_front();
                    eb = exp_blk_q.pop_front();
                    check("digest_model", digest, ed);
                    check("h_final", {h0, h1, h2, h3, h4}, ed);
                    check("block_count", 160'(rst_cnt), 160'(eb));
                end
                rst_cnt = 0;
            end
            if (busy) check("in_ready_busy", 160'(in_ready), 160'(0));
            if (in_valid && in_ready && in_last) busy = 1'b1;
            acc_prev = in_valid && in_ready;
            dv_prev  = digest_valid;
        end
    end

    task automatic send(input msg_t m, input int gap_pct);
        int idx = 0;
        int cyc = 0;
        exp_dig_q.push_back(sha1_ref(m));
        exp_blk_q.push_back((m.size() + 8) / 64 + 1);
        while (idx < m.size()) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 5000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got %0d bytes expected %0d", idx, m.size());
                in_valid = 1'b0;
                return;
            end
            if ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                continue;
            end
            in_valid = 1'b1;
            in_data  = m[idx];
            in_last  = (idx == m.size() - 1);
            if (in_ready) idx++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_digest();
        int cyc = 0;
        @(negedge clk);
        while (!digest_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!digest_valid) begin
            checks++;
            errors++;
            $display("FAIL digest_timeout: got digest_valid 0 expected 1");
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 160'(in_ready), 160'(0));
        check({tag, "_restart"}, 160'(core_restart), 160'(0));
        check({tag, "_dv"}, 160'(digest_valid), 160'(0));
        check({tag, "_digest"}, digest, 160'(0));
        check({tag, "_h"}, {h0, h1, h2, h3, h4}, IV);
        check({tag, "_word"}, 160'(core_word), 160'(0));
    endtask

    initial begin
        msg_t m_abc, m_fox, m_56, m;
        int   lens [11] = '{1, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};
        int   cyc;

        m_abc = str2msg("abc");
        m_fox = str2msg("The quick brown fox jumps over the lazy dog");
        m_56  = str2msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");

        nrst     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst0");
        @(posedge clk);
        #2 nrst = 1'b1;

        // Hand-computed digests pin the reference model itself.
        check("ref_abc", sha1_ref(m_abc), DIG_ABC);
        check("ref_fox", sha1_ref(m_fox), DIG_FOX);
        check("ref_56", sha1_ref(m_56), DIG_56);

        send(m_abc, 0);
        wait_digest();
        check("abc", digest, DIG_ABC);

        send(m_fox, 0);
        wait_digest();
        check("fox", digest, DIG_FOX);

        send(m_56, 0);
        wait_digest();
        check("two_block_56", digest, DIG_56);

        send(m_fox, 40);
        wait_digest();
        check("fox_gaps", digest, DIG_FOX);

        send(m_abc, 0);
        send(m_56, 0);
        wait_digest();
        check("back_to_back_56", digest, DIG_56);

        // Reset in the middle of the first block of a two-block message.
        send(m_56, 0);
        cyc = 0;
        while (!core_restart && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_seen", 160'(core_restart), 160'(1));
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1 check_reset_values("rst_mid");
        @(posedge clk);
        #2 check_reset_values("rst_hold");
        nrst = 1'b1;
        send(m_abc, 0);
        wait_digest();
        check("abc_after_reset", digest, DIG_ABC);

        for (int t = 0; t < 17; t++) begin
            int n;
            n = (t < 11) ? lens[t] : $urandom_range(1, 150);
            m.delete();
            for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
            send(m, 25);
            wait_digest();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 160'(exp_dig_q.size()), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
